// File: rtl/operand_fetch_stage_pkg.sv
// Shared types for the operand fetch stage and its neighbours.
// Default widths and the decode-to-execute payload live here.
package operand_fetch_stage_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_NUM_REGS   = 8;
    localparam int DEF_ADDR_WIDTH = $clog2(DEF_NUM_REGS);

    typedef logic [DEF_ADDR_WIDTH-1:0] reg_addr_t;
    typedef logic [DEF_DATA_WIDTH-1:0] reg_data_t;

    typedef struct packed {
        reg_data_t op_a;
        reg_data_t op_b;
        reg_data_t imm;
        reg_addr_t rd;
        logic      rd_we;
    } id_ex_t;

endpackage

// File: rtl/operand_fetch_stage_regfile_bypass.sv
// Architectural register file: one synchronous write port and
// two combinational read ports that see same-cycle writeback data.
module regfile_bypass
    import operand_fetch_stage_pkg::*;
#(
    parameter int  DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int  NUM_REGS   = DEF_NUM_REGS,
    localparam int ADDR_WIDTH = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wb_en,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic [DATA_WIDTH-1:0] wb_data,
    input  logic [ADDR_WIDTH-1:0] rs1,
    input  logic [ADDR_WIDTH-1:0] rs2,
    output logic [DATA_WIDTH-1:0] rd_a,
    output logic [DATA_WIDTH-1:0] rd_b
);

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

    always_comb begin
        regs_d = regs_q;
        if (wb_en) begin
            regs_d[wb_addr] = wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rd_a = (wb_en && wb_addr == rs1) ? wb_data : regs_q[rs1];
    assign rd_b = (wb_en && wb_addr == rs2) ? wb_data : regs_q[rs2];

endmodule

// File: rtl/operand_fetch_stage.sv
// Operand fetch: register read with bypass, scoreboard hazard stall
// and the decode-to-execute pipeline register.
module operand_fetch_stage
    import operand_fetch_stage_pkg::*;
#(
    parameter int  DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int  NUM_REGS   = DEF_NUM_REGS,
    localparam int ADDR_WIDTH = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  dec_valid,
    output logic                  dec_ready,
    input  logic [ADDR_WIDTH-1:0] dec_rs1,
    input  logic [ADDR_WIDTH-1:0] dec_rs2,
    input  logic [ADDR_WIDTH-1:0] dec_rd,
    input  logic                  dec_rd_we,
    input  logic [DATA_WIDTH-1:0] dec_imm,
    input  logic                  wb_en,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic                  ex_valid,
    input  logic                  ex_ready,
    output logic [DATA_WIDTH-1:0] ex_op_a,
    output logic [DATA_WIDTH-1:0] ex_op_b,
    output logic [DATA_WIDTH-1:0] ex_imm,
    output logic [ADDR_WIDTH-1:0] ex_rd,
    output logic                  ex_rd_we
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] op_a;
        logic [DATA_WIDTH-1:0] op_b;
        logic [DATA_WIDTH-1:0] imm;
        logic [ADDR_WIDTH-1:0] rd;
        logic                  rd_we;
    } payload_t;

    payload_t              ex_q, ex_d;
    logic                  ex_valid_q, ex_valid_d;
    logic [NUM_REGS-1:0]   pending_q, pending_d;
    logic [NUM_REGS-1:0]   wb_mask, set_mask, busy;
    logic [DATA_WIDTH-1:0] rd_a, rd_b;
    logic                  hazard, out_free, accept;

    regfile_bypass #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS)
    ) u_regfile (
        .clk     (clk),
        .reset   (reset),
        .wb_en   (wb_en),
        .wb_addr (wb_addr),
        .wb_data (wb_data),
        .rs1     (dec_rs1),
        .rs2     (dec_rs2),
        .rd_a    (rd_a),
        .rd_b    (rd_b)
    );

    always_comb begin
        wb_mask    = wb_en ? (NUM_REGS'(1) << wb_addr) : '0;
        // A writeback landing this cycle already resolves its register.
        busy       = pending_q & ~wb_mask;
        hazard     = busy[dec_rs1] | busy[dec_rs2]
                   | (dec_rd_we & busy[dec_rd]);
        out_free   = !ex_valid_q || ex_ready;
        dec_ready  = out_free && !hazard;
        accept     = dec_valid && dec_ready;
        set_mask   = (accept && dec_rd_we) ? (NUM_REGS'(1) << dec_rd) : '0;
        pending_d  = (pending_q & ~wb_mask) | set_mask;
        ex_d       = ex_q;
        ex_valid_d = ex_valid_q;
        if (accept) begin
            ex_d.op_a  = rd_a;
            ex_d.op_b  = rd_b;
            ex_d.imm   = dec_imm;
            ex_d.rd    = dec_rd;
            ex_d.rd_we = dec_rd_we;
            ex_valid_d = 1'b1;
        end else if (ex_ready) begin
            ex_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q       <= '0;
            ex_valid_q <= 1'b0;
            pending_q  <= '0;
        end else begin
            ex_q       <= ex_d;
            ex_valid_q <= ex_valid_d;
            pending_q  <= pending_d;
        end
    end

    assign ex_valid = ex_valid_q;
    assign ex_op_a  = ex_q.op_a;
    assign ex_op_b  = ex_q.op_b;
    assign ex_imm   = ex_q.imm;
    assign ex_rd    = ex_q.rd;
    assign ex_rd_we = ex_q.rd_we;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Randomised and directed bench for operand_fetch_stage against a
// behavioural model of the register file, scoreboard and handshake.
module tb_operand_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        dec_valid, dec_ready;
    logic [2:0]  dec_rs1, dec_rs2, dec_rd;
    logic        dec_rd_we;
    logic [15:0] dec_imm;
    logic        wb_en;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic        ex_valid, ex_ready;
    logic [15:0] ex_op_a, ex_op_b, ex_imm;
    logic [2:0]  ex_rd;
    logic        ex_rd_we;

    int n_chk  = 0;
    int n_fail = 0;

    operand_fetch_stage dut (
        .clk       (clk),
        .reset     (reset),
        .dec_valid (dec_valid),
        .dec_ready (dec_ready),
        .dec_rs1   (dec_rs1),
        .dec_rs2   (dec_rs2),
        .dec_rd    (dec_rd),
        .dec_rd_we (dec_rd_we),
        .dec_imm   (dec_imm),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .ex_valid  (ex_valid),
        .ex_ready  (ex_ready),
        .ex_op_a   (ex_op_a),
        .ex_op_b   (ex_op_b),
        .ex_imm    (ex_imm),
        .ex_rd     (ex_rd),
        .ex_rd_we  (ex_rd_we)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: architectural state as plain arrays.
    logic [15:0] m_regs [8];
    bit          m_pend [8];
    bit          m_v, m_we, m_known;
    logic [15:0] m_a, m_b, m_imm;
    logic [2:0]  m_rd;
    bit          e_rdy, e_acc;

    function automatic bit busy(input logic [2:0] r);
        return m_pend[r] && !(wb_en && wb_addr == r);
    endfunction

    function automatic logic [15:0] rd_val(input logic [2:0] r);
        return (wb_en && wb_addr == r) ? wb_data : m_regs[r];
    endfunction

    // Inputs change only just after posedge, so negedge sees what the edge will.
    always @(negedge clk) begin
        e_rdy = (!m_v || ex_ready) &&
                !(busy(dec_rs1) || busy(dec_rs2) || (dec_rd_we && busy(dec_rd)));
        e_acc = dec_valid && e_rdy;
        if (m_known) begin
            chk("m_dec_ready", {31'b0, dec_ready}, {31'b0, e_rdy});
            chk("m_ex_valid", {31'b0, ex_valid}, {31'b0, m_v});
            chk("m_ex_op_a", {16'b0, ex_op_a}, {16'b0, m_a});
            chk("m_ex_op_b", {16'b0, ex_op_b}, {16'b0, m_b});
            chk("m_ex_imm", {16'b0, ex_imm}, {16'b0, m_imm});
            chk("m_ex_rd", {29'b0, ex_rd}, {29'b0, m_rd});
            chk("m_ex_rd_we", {31'b0, ex_rd_we}, {31'b0, m_we});
        end
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                m_regs[i] = '0;
                m_pend[i] = 0;
            end
            m_v = 0; m_we = 0; m_a = '0; m_b = '0; m_imm = '0; m_rd = '0;
            m_known = 1;
        end else if (m_known) begin
            if (e_acc) begin
                m_a = rd_val(dec_rs1);
                m_b = rd_val(dec_rs2);
                m_imm = dec_imm;
                m_rd = dec_rd;
                m_we = dec_rd_we;
                m_v = 1;
            end else if (ex_ready) begin
                m_v = 0;
            end
            if (wb_en) begin
                m_regs[wb_addr] = wb_data;
                m_pend[wb_addr] = 0;
            end
            if (e_acc && dec_rd_we) m_pend[dec_rd] = 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        dec_valid = 0; dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0;
        dec_rd_we = 0; dec_imm = 0; wb_en = 0; wb_addr = 0; wb_data = 0;
    endtask

    task automatic issue(input logic [2:0] rs1, input logic [2:0] rs2,
                         input logic [2:0] rd, input logic we,
                         input logic [15:0] imm);
        dec_valid = 1; dec_rs1 = rs1; dec_rs2 = rs2;
        dec_rd = rd; dec_rd_we = we; dec_imm = imm;
    endtask

    task automatic wb(input logic en, input logic [2:0] a, input logic [15:0] d);
        wb_en = en; wb_addr = a; wb_data = d;
    endtask

    initial begin
        m_known = 0;
        idle();
        ex_ready = 1;
        reset = 1;
        wb(1, 3, 16'hFFFF);
        step(); step();
        chk("rst_ex_valid", {31'b0, ex_valid}, 32'd0);
        chk("rst_ex_op_a", {16'b0, ex_op_a}, 32'd0);
        chk("rst_ex_imm", {16'b0, ex_imm}, 32'd0);
        chk("rst_ex_rd_we", {31'b0, ex_rd_we}, 32'd0);
        reset = 0;
        idle();
        issue(3, 3, 0, 0, 0);
        step();
        chk("rst_r3", {16'b0, ex_op_a}, 32'h0000);
        chk("rst_r3_valid", {31'b0, ex_valid}, 32'd1);

        wb(1, 2, 16'h1234);
        issue(2, 2, 0, 0, 0);
        #1 chk("byp_ready", {31'b0, dec_ready}, 32'd1);
        step();
        chk("byp_a", {16'b0, ex_op_a}, 32'h1234);
        chk("byp_b", {16'b0, ex_op_b}, 32'h1234);
        wb(0, 0, 0);

        issue(0, 0, 5, 1, 0);
        step();
        issue(5, 0, 0, 0, 0);
        #1 chk("raw_stall0", {31'b0, dec_ready}, 32'd0);
        step();
        #1 chk("raw_stall1", {31'b0, dec_ready}, 32'd0);
        wb(1, 5, 16'h00AB);
        #1 chk("raw_wb_ready", {31'b0, dec_ready}, 32'd1);
        step();
        chk("raw_op_a", {16'b0, ex_op_a}, 32'h00AB);
        wb(0, 0, 0);

        ex_ready = 0;
        issue(2, 3, 6, 0, 16'h0055);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_ready", {31'b0, dec_ready}, 32'd0);
            chk("bp_hold_a", {16'b0, ex_op_a}, 32'h00AB);
            chk("bp_valid", {31'b0, ex_valid}, 32'd1);
            step();
        end
        ex_ready = 1;
        #1 chk("bp_release", {31'b0, dec_ready}, 32'd1);
        step();
        chk("bp_new_a", {16'b0, ex_op_a}, 32'h1234);
        chk("bp_new_imm", {16'b0, ex_imm}, 32'h0055);
        chk("bp_new_rd", {29'b0, ex_rd}, 32'd6);

        issue(0, 0, 4, 1, 0);
        step();
        wb(1, 4, 16'h4444);
        issue(0, 0, 4, 1, 0);
        #1 chk("sbc_accept", {31'b0, dec_ready}, 32'd1);
        step();
        wb(0, 0, 0);
        issue(4, 0, 0, 0, 0);
        #1 chk("sbc_stall", {31'b0, dec_ready}, 32'd0);
        step();
        issue(0, 0, 4, 1, 0);
        #1 chk("waw_stall", {31'b0, dec_ready}, 32'd0);
        wb(1, 4, 16'h5555);
        issue(4, 0, 0, 0, 0);
        #1 chk("sbc_2nd_wb", {31'b0, dec_ready}, 32'd1);
        step();
        wb(0, 0, 0);
        chk("sbc_op_a", {16'b0, ex_op_a}, 32'h5555);

        idle();
        for (int i = 0; i < 8; i++) begin
            wb(1, 3'(i), 16'h0010 + 16'(i));
            step();
        end
        idle();
        for (int i = 0; i < 8; i++) begin
            issue(3'(i), 3'(7 - i), 0, 0, 16'(i));
            #1 chk("str_ready", {31'b0, dec_ready}, 32'd1);
            step();
            chk("str_valid", {31'b0, ex_valid}, 32'd1);
            chk("str_a", {16'b0, ex_op_a}, 32'h0010 + 32'(i));
            chk("str_b", {16'b0, ex_op_b}, 32'h0017 - 32'(i));
        end
        idle();
        step();
        chk("str_drain", {31'b0, ex_valid}, 32'd0);

        for (int c = 0; c < 3000; c++) begin
            reset     = ($urandom_range(0, 249) == 0);
            dec_valid = 1'($urandom);
            dec_rs1   = 3'($urandom);
            dec_rs2   = 3'($urandom);
            dec_rd    = 3'($urandom);
            dec_rd_we = 1'($urandom);
            dec_imm   = 16'($urandom);
            wb_en     = ($urandom_range(0, 1) == 1);
            wb_addr   = 3'($urandom);
            wb_data   = 16'($urandom);
            ex_ready  = ($urandom_range(0, 9) < 7);
            step();
        end

        reset = 0;
        idle();
        ex_ready = 1;
        repeat (4) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
